sd_cic_decimator: RTL and testbench
===================================

Name: sd_cic_decimator

Overview:
- Receive-side counterpart of the sigma-delta DAC: converts a 1-bit sigma-delta bitstream back into signed 16-bit PCM samples.
- Uses a 3rd-order CIC (sinc3) decimator with power-of-two decimation ratio.
- Used in loopback benches behind the sddac and as the front end of a bitstream ADC path.
- Emits one PCM sample with a single-cycle valid strobe per DECIM accepted input bits.

Parameters:
- LOG2_DECIM, 6: log2 of decimation ratio DECIM. Legal range 5..8; default DECIM=64.
- OUT_W, 16: PCM output width. Fixed at 16; no other value supported.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- bs_in  in  1  sigma-delta bitstream; 1 = +1, 0 = -1
- bs_en  in  1  bit-accept strobe; bs_in is consumed only on cycles where bs_en=1
- pcm_out  out  16  signed PCM sample; holds its value between strobes
- pcm_valid  out  1  one-cycle pulse when pcm_out is updated
- sat_flag  out  1  high together with pcm_valid when the sample was clipped; 0 otherwise

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Clears integrators, comb delays, bit counter and warm-up counter.
  - pcm_out=0, pcm_valid=0, sat_flag=0.
  - Reset mid-stream discards all history, including a partially accumulated sample.
- Internal width: W = 3*LOG2_DECIM+2. All integrator and comb arithmetic is two's-complement modulo 2^W; wrap-around is intentional and must not be saturated. Gain = DECIM^3 = 2^(3*LOG2_DECIM).
- Integrators: on each bs_en cycle, with x = bs_in ? +1 : -1 and all right-hand terms being pre-edge register values:
  - i1 <= i1 + x
  - i2 <= i2 + i1
  - i3 <= i3 + i2
  - No integrator changes when bs_en=0.
- Bit counter cnt (LOG2_DECIM bits) increments on bs_en and wraps DECIM-1 -> 0.
- tick = bs_en & (cnt == DECIM-1).
- On the tick edge, the comb stage operates on s = current (pre-edge) i3:
  - c1 = s - d1; c2 = c1 - d2; c3 = c2 - d3
  - d1 <= s, d2 <= c1, d3 <= c2
- Output scaling: y = c3 >>> SHIFT (arithmetic shift), where SHIFT = 3*LOG2_DECIM-15.
  - Saturate y to [-32768, 32767].
  - sat_flag=1 iff y was outside that range.
- Output timing:
  - On a tick edge, pcm_out and sat_flag are registered and pcm_valid<=1.
  - pcm_valid is high for exactly the cycle following the tick edge; otherwise pcm_valid<=0 and sat_flag<=0.
  - pcm_out holds its value between strobes.
- Warm-up: a 2-bit counter suppresses the first 3 ticks after reset.
  - During suppression, comb delays update but pcm_out, pcm_valid and sat_flag stay at reset values.
  - The first pcm_valid follows the 4th tick, i.e. accepted bit number 4*DECIM.
- Throughput: one sample per DECIM accepted bits. bs_en gaps stretch the output period but do not change any value.
- bs_en held low: complete freeze. There is no timeout.

Test Plan:
- Reset: rst_n=0 for 4 cycles with bs_en=1 and toggling bs_in -> pcm_out=0, pcm_valid=0, sat_flag=0 throughout. Release rst_n -> no pcm_valid before 256 accepted bits.
- Full-scale positive (LOG2_DECIM=6, bs_en=1, bs_in=1):
  - First pcm_valid on the cycle after the 256th accepted bit.
  - pcm_out=32767, sat_flag=1.
  - Repeats every 64 cycles.
- Full-scale negative (bs_in=0) -> pcm_out=-32768 (exactly -2^18>>>3), sat_flag=0, every 64 cycles.
- Zero mean (bs_in alternating 1,0,1,0,...) -> every valid pcm_out=0, sat_flag=0.
- Pattern 1,1,1,0 repeated -> every valid pcm_out=16384.
- Gating and reset:
  - bs_en high every other cycle with bs_in=1 -> pcm_valid every 128 cycles, value 32767.
  - Assert rst_n=0 for 1 cycle mid-sample -> pcm_valid=0 and pcm_out=0 next cycle.
  - After release, the next pcm_valid comes only after another 256 accepted bits.

Source files
------------

// File: rtl/sd_cic_decimator_if.sv
// Bitstream-in / PCM-out bus of the sinc3 decimator.
interface sd_cic_decimator_if #(
  parameter int unsigned OUT_W = 16
);
  logic                    bs_in;
  logic                    bs_en;
  logic signed [OUT_W-1:0] pcm_out;
  logic                    pcm_valid;
  logic                    sat_flag;

  // Bitstream source / PCM consumer side
  modport master (
    output bs_in,
    output bs_en,
    input  pcm_out,
    input  pcm_valid,
    input  sat_flag
  );

  // Decimator side
  modport slave (
    input  bs_in,
    input  bs_en,
    output pcm_out,
    output pcm_valid,
    output sat_flag
  );
endinterface

// File: rtl/sd_cic_decimator.sv
// 3rd-order CIC (sinc3) decimator: 1-bit sigma-delta stream to signed PCM.
// Integrators and combs wrap modulo 2^W by design; only the final PCM
// value is saturated.
module sd_cic_decimator #(
  parameter int unsigned LOG2_DECIM = 6,
  parameter int unsigned OUT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  sd_cic_decimator_if.slave cic_if
);

  localparam int unsigned W     = 3 * LOG2_DECIM + 2;
  localparam int unsigned SHIFT = 3 * LOG2_DECIM - 15;

  localparam logic signed [W-1:0] PCM_MAX = W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [W-1:0] PCM_MIN = W'(-(2 ** (OUT_W - 1)));

  // Warm-up: the first three comb outputs see an unfilled window
  typedef enum logic [1:0] {
    ST_WARM0,
    ST_WARM1,
    ST_WARM2,
    ST_RUN
  } state_e;

  state_e state_q, state_d;

  logic signed [W-1:0]     i1_q, i2_q, i3_q;
  logic signed [W-1:0]     i1_d, i2_d, i3_d;
  logic signed [W-1:0]     d1_q, d2_q, d3_q;
  logic signed [W-1:0]     d1_d, d2_d, d3_d;
  logic [LOG2_DECIM-1:0]   cnt_q, cnt_d;
  logic signed [OUT_W-1:0] pcm_q, pcm_d;
  logic                    valid_q, valid_d;
  logic                    sat_q, sat_d;

  logic signed [W-1:0]     x_c;
  logic signed [W-1:0]     c1_c, c2_c, c3_c;
  logic signed [W-1:0]     y_c;
  logic signed [OUT_W-1:0] pcm_sat_c;
  logic                    clip_c;
  logic                    tick_c;

  assign x_c    = cic_if.bs_in ? W'(1) : '1;
  assign tick_c = cic_if.bs_en & (&cnt_q);

  assign c1_c = i3_q - d1_q;
  assign c2_c = c1_c - d2_q;
  assign c3_c = c2_c - d3_q;
  assign y_c  = c3_c >>> SHIFT;

  // Clip the scaled comb output to the PCM range
  always_comb begin
    pcm_sat_c = y_c[OUT_W-1:0];
    clip_c    = 1'b0;
    if (y_c > PCM_MAX) begin
      pcm_sat_c = PCM_MAX[OUT_W-1:0];
      clip_c    = 1'b1;
    end else if (y_c < PCM_MIN) begin
      pcm_sat_c = PCM_MIN[OUT_W-1:0];
      clip_c    = 1'b1;
    end
  end

  // Integrator chain, bit counter and comb delays
  always_comb begin
    i1_d  = i1_q;
    i2_d  = i2_q;
    i3_d  = i3_q;
    cnt_d = cnt_q;
    d1_d  = d1_q;
    d2_d  = d2_q;
    d3_d  = d3_q;
    if (cic_if.bs_en) begin
      i1_d  = i1_q + x_c;
      i2_d  = i2_q + i1_q;
      i3_d  = i3_q + i2_q;
      cnt_d = cnt_q + LOG2_DECIM'(1);
    end
    if (tick_c) begin
      d1_d = i3_q;
      d2_d = c1_c;
      d3_d = c2_c;
    end
  end

  // Warm-up sequencing and output strobe generation
  always_comb begin
    state_d = state_q;
    pcm_d   = pcm_q;
    valid_d = 1'b0;
    sat_d   = 1'b0;
    if (tick_c) begin
      case (state_q)
        ST_WARM0: state_d = ST_WARM1;
        ST_WARM1: state_d = ST_WARM2;
        ST_WARM2: state_d = ST_RUN;
        ST_RUN: begin
          state_d = ST_RUN;
          pcm_d   = pcm_sat_c;
          valid_d = 1'b1;
          sat_d   = clip_c;
        end
        default: state_d = ST_WARM0;
      endcase
    end
  end

  // Warm-up state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_WARM0;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i1_q    <= '0;
      i2_q    <= '0;
      i3_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      cnt_q   <= '0;
      pcm_q   <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      i1_q    <= i1_d;
      i2_q    <= i2_d;
      i3_q    <= i3_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      d3_q    <= d3_d;
      cnt_q   <= cnt_d;
      pcm_q   <= pcm_d;
      valid_q <= valid_d;
      sat_q   <= sat_d;
    end
  end

  assign cic_if.pcm_out   = pcm_q;
  assign cic_if.pcm_valid = valid_q;
  assign cic_if.sat_flag  = sat_q;

endmodule

// File: tb/tb_sd_cic_decimator.sv
// Bench for sd_cic_decimator: closed-form sinc3 model plus literal checks.
module tb_sd_cic_decimator;

  localparam int unsigned LOG2_DECIM = 6;
  localparam int          D          = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sd_cic_decimator_if bus ();

  sd_cic_decimator #(
    .LOG2_DECIM(LOG2_DECIM),
    .OUT_W     (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cic_if(bus)
  );

  int nvec = 0;
  int nerr = 0;

  // Model state: accepted bits since reset and integrator-3 value per tick
  int                 hist[$];
  longint             slist[$];
  logic               exp_valid = 1'b0;
  logic signed [15:0] exp_pcm = '0;
  logic               exp_sat = 1'b0;

  // Per-run observations
  int                 first_v;
  int                 prev_v;
  int                 last_gap;
  int                 nvalid;
  logic signed [15:0] last_pcm;
  logic               last_sat;

  task automatic chk(input string name, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint s_at(input int idx);
    if (idx < 0) return 0;
    return slist[idx];
  endfunction

  // Sinc3 model: after m accepted bits the third integrator holds
  // sum_p x_p * C(m-1-p, 2); the comb is a third difference across ticks.
  task automatic model(input logic r, input logic e, input logic b);
    int     m;
    int     k;
    longint s;
    longint n;
    longint c3;
    longint y;
    if (!r) begin
      hist.delete();
      slist.delete();
      exp_valid = 1'b0;
      exp_pcm   = '0;
      exp_sat   = 1'b0;
    end else begin
      exp_valid = 1'b0;
      exp_sat   = 1'b0;
      if (e) begin
        m = hist.size();
        hist.push_back(b ? 1 : -1);
        if (((m + 1) % D) == 0) begin
          s = 0;
          for (int p = 0; p < m; p++) begin
            n = longint'(m - 1 - p);
            s += longint'(hist[p]) * ((n * (n - 1)) / 2);
          end
          slist.push_back(s);
          k  = slist.size();
          c3 = s - 3 * s_at(k - 2) + 3 * s_at(k - 3) - s_at(k - 4);
          if (k >= 4) begin
            y = c3 >>> 3;
            exp_valid = 1'b1;
            if (y > 32767) begin
              exp_pcm = 16'sd32767;
              exp_sat = 1'b1;
            end else if (y < -32768) begin
              exp_pcm = -16'sd32768;
              exp_sat = 1'b1;
            end else begin
              exp_pcm = 16'(y);
            end
          end
        end
      end
    end
  endtask

  // One clock: drive, update model at the edge, compare at the falling edge
  task automatic step(input logic r, input logic e, input logic b, input int cyc);
    rst_n      = r;
    bus.bs_en  = e;
    bus.bs_in  = b;
    @(posedge clk);
    model(r, e, b);
    @(negedge clk);
    chk("pcm_valid", longint'(bus.pcm_valid), longint'(exp_valid));
    chk("pcm_out", longint'(bus.pcm_out), longint'(exp_pcm));
    chk("sat_flag", longint'(bus.sat_flag), longint'(exp_sat));
    if (bus.pcm_valid) begin
      nvalid++;
      if (first_v < 0) first_v = cyc;
      else last_gap = cyc - prev_v;
      prev_v   = cyc;
      last_pcm = bus.pcm_out;
      last_sat = bus.sat_flag;
    end
  endtask

  task automatic do_reset(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      step(1'b0, 1'b1, 1'(i % 2), 0);
      chk("rst_valid", longint'(bus.pcm_valid), 0);
      chk("rst_pcm", longint'(bus.pcm_out), 0);
      chk("rst_sat", longint'(bus.sat_flag), 0);
    end
  endtask

  // pat: 0 all ones, 1 all zeros, 2 alternating, 3 repeating 1,1,1,0
  task automatic run(input int ncyc, input int pat, input int en_every);
    int   acc;
    logic e;
    logic b;
    acc      = 0;
    first_v  = -1;
    prev_v   = -1;
    last_gap = -1;
    nvalid   = 0;
    last_pcm = '0;
    last_sat = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      e = ((c - 1) % en_every) == 0;
      case (pat)
        0:       b = 1'b1;
        1:       b = 1'b0;
        2:       b = (acc % 2) == 0;
        default: b = (acc % 4) != 3;
      endcase
      step(1'b1, e, b, c);
      if (e) acc++;
    end
  endtask

  initial begin
    bus.bs_in = 1'b0;
    bus.bs_en = 1'b0;

    do_reset(4);
    run(448, 0, 1);
    chk("pos_first", first_v, 256);
    chk("pos_gap", last_gap, 64);
    chk("pos_count", nvalid, 4);
    chk("pos_pcm", longint'(last_pcm), 32767);
    chk("pos_sat", longint'(last_sat), 1);

    do_reset(2);
    run(448, 1, 1);
    chk("neg_first", first_v, 256);
    chk("neg_gap", last_gap, 64);
    chk("neg_pcm", longint'(last_pcm), -32768);
    chk("neg_sat", longint'(last_sat), 0);

    do_reset(2);
    run(448, 2, 1);
    chk("zero_count", nvalid, 4);
    chk("zero_pcm", longint'(last_pcm), 0);
    chk("zero_sat", longint'(last_sat), 0);

    do_reset(2);
    run(448, 3, 1);
    chk("p1110_count", nvalid, 4);
    chk("p1110_pcm", longint'(last_pcm), 16384);
    chk("p1110_sat", longint'(last_sat), 0);

    do_reset(2);
    run(1024, 0, 2);
    chk("gated_first", first_v, 511);
    chk("gated_gap", last_gap, 128);
    chk("gated_count", nvalid, 5);
    chk("gated_pcm", longint'(last_pcm), 32767);

    do_reset(2);
    run(300, 0, 1);
    chk("pre_rst_pcm", longint'(last_pcm), 32767);
    step(1'b0, 1'b1, 1'b1, 0);
    chk("midrst_valid", longint'(bus.pcm_valid), 0);
    chk("midrst_pcm", longint'(bus.pcm_out), 0);
    run(300, 0, 1);
    chk("post_rst_first", first_v, 256);
    chk("post_rst_count", nvalid, 1);
    chk("post_rst_pcm", longint'(last_pcm), 32767);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
